// File: rtl/row_packer.sv
// row_packer
//   Packs a stream of ROW_SIZE-bit words into PAR_WRITE-word groups and
//   offers each group to the circular buffer's write port. The first
//   accepted word of a group lands in the most-significant slice. A flush
//   zero-pads a partial group and pushes it.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous reset, active low
//   in_valid/in_data upstream word and its valid
//   in_ready         word is accepted this cycle when in_valid is also high
//   flush            one-cycle request to pad and push a partial group
//   buf_ready        circular buffer accepts a group this cycle
//   buf_write_enable packed group present on buf_din (registered)
//   buf_din          packed group
//   busy             a partial or complete group is held
//   group_count      groups transferred since reset, wraps at 2^16
module row_packer #(
  parameter int ROW_SIZE  = 8,
  parameter int PAR_WRITE = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [ROW_SIZE-1:0]           in_data,
  output logic                          in_ready,
  input  logic                          flush,
  input  logic                          buf_ready,
  output logic                          buf_write_enable,
  output logic [ROW_SIZE*PAR_WRITE-1:0] buf_din,
  output logic                          busy,
  output logic [15:0]                   group_count
);

  localparam int GRP_W = ROW_SIZE * PAR_WRITE;
  localparam int CNT_W = $clog2(PAR_WRITE + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PAR_WRITE);

  logic [GRP_W-1:0] pack_q;
  logic [GRP_W-1:0] pack_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] base_cnt;
  logic [CNT_W-1:0] fill_cnt;
  logic             full;
  logic             xfer;
  logic             accept;

  // The pack register is cleared whenever a group leaves, so slots beyond
  // the fill count are always zero. Flush therefore only has to declare the
  // group full; the padding is already in place.
  always_comb begin
    full     = (cnt_q == FULL_CNT);
    xfer     = full && buf_ready;
    in_ready = !full || buf_ready;
    accept   = in_valid && in_ready;

    // A group leaving on this edge frees the register for the incoming word.
    base_cnt = xfer ? '0 : cnt_q;
    pack_d   = xfer ? '0 : pack_q;

    if (accept) begin
      for (int i = 0; i < PAR_WRITE; i++) begin
        if (base_cnt == CNT_W'(i)) begin
          pack_d[GRP_W-1-i*ROW_SIZE -: ROW_SIZE] = in_data;
        end
      end
    end

    fill_cnt = base_cnt + CNT_W'(accept);
    cnt_d    = fill_cnt;
    // Flush acts on the count after this cycle's word; empty or already
    // full groups are left alone.
    if (flush && (fill_cnt != '0) && (fill_cnt < FULL_CNT)) begin
      cnt_d = FULL_CNT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      pack_q      <= '0;
      group_count <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pack_q <= pack_d;
      if (xfer) begin
        group_count <= group_count + 16'd1;
      end
    end
  end

  assign buf_write_enable = full;
  assign buf_din          = pack_q;
  assign busy             = (cnt_q != '0);

endmodule

// File: tb/tb_row_packer.sv
// tb_row_packer
//   Drives row_packer (ROW_SIZE=8, PAR_WRITE=2) with directed sequences and
//   randomized traffic, comparing every cycle against a word-queue model.
module tb_row_packer;

  localparam int RS = 8;
  localparam int PW = 2;
  localparam int W  = RS * PW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [RS-1:0] in_data = '0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          buf_ready = 1'b0;
  logic          buf_write_enable;
  logic [W-1:0]  buf_din;
  logic          busy;
  logic [15:0]   group_count;

  row_packer #(.ROW_SIZE(RS), .PAR_WRITE(PW)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .flush            (flush),
    .buf_ready        (buf_ready),
    .buf_write_enable (buf_write_enable),
    .buf_din          (buf_din),
    .busy             (busy),
    .group_count      (group_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: words of the group being built, plus at most one
  // complete group waiting for the buffer.
  logic [RS-1:0] m_words[$];
  bit            m_held = 1'b0;
  logic [W-1:0]  m_held_data = '0;
  int            m_count = 0;
  bit            m_known = 1'b0;

  // Groups observed leaving the DUT.
  logic [W-1:0]  obs[$];

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_words();
    logic [W-1:0] d = '0;
    for (int i = 0; i < m_words.size(); i++) d[W-1-i*RS -: RS] = m_words[i];
    return d;
  endfunction

  task automatic model_step();
    bit rdy;
    if (!rst) begin
      m_words.delete();
      m_held      = 1'b0;
      m_held_data = '0;
      m_count     = 0;
      m_known     = 1'b1;
    end else begin
      rdy = !m_held || buf_ready;
      if (m_held && buf_ready) begin
        m_held = 1'b0;
        m_count++;
      end
      if (in_valid && rdy) begin
        m_words.push_back(in_data);
        if (m_words.size() == PW) begin
          m_held_data = pack_words();
          m_held      = 1'b1;
          m_words.delete();
        end
      end
      if (flush && !m_held && m_words.size() > 0) begin
        m_held_data = pack_words();
        m_held      = 1'b1;
        m_words.delete();
      end
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model at the edge,
  // return just after the edge so the caller can drive the next inputs.
  task automatic cycle();
    @(negedge clk);
    if (m_known) begin
      check_val("we", 32'(buf_write_enable), 32'(m_held));
      check_val("in_ready", 32'(in_ready), 32'(!m_held || buf_ready));
      check_val("busy", 32'(busy), 32'(m_held || m_words.size() != 0));
      check_val("group_count", 32'(group_count), 32'(m_count[15:0]));
      if (m_held) check_val("buf_din", 32'(buf_din), 32'(m_held_data));
    end
    if (buf_write_enable === 1'b1 && buf_ready === 1'b1) obs.push_back(buf_din);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    cycle();
    rst = 1'b1;
    obs.delete();
  endtask

  task automatic send(input logic [RS-1:0] w);
    in_valid = 1'b1; in_data = w;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset with in_valid and flush active.
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hAA; flush = 1'b1; buf_ready = 1'b1;
    cycle();
    cycle();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    check_val("rst_we", 32'(buf_write_enable), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_gc", 32'(group_count), 32'd0);
    check_val("rst_din", 32'(buf_din), 32'd0);
    check_val("rst_ready", 32'(in_ready), 32'd1);

    // Basic pack.
    obs.delete();
    buf_ready = 1'b1;
    send(8'd12);
    send(8'd13);
    check_val("basic_we", 32'(buf_write_enable), 32'd1);
    check_val("basic_din", 32'(buf_din), 32'h0C0D);
    cycle();
    check_val("basic_gc", 32'(group_count), 32'd1);
    check_val("basic_busy", 32'(busy), 32'd0);
    check_val("basic_nobs", obs.size(), 32'd1);

    // Backpressure: 16 must wait until the held group leaves.
    do_reset();
    buf_ready = 1'b0;
    send(8'd14);
    send(8'd15);
    in_valid = 1'b1; in_data = 8'd16;
    cycle();
    cycle();
    check_val("bp_din", 32'(buf_din), 32'h0E0F);
    check_val("bp_ready", 32'(in_ready), 32'd0);
    check_val("bp_gc", 32'(group_count), 32'd0);
    buf_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check_val("bp_gc1", 32'(group_count), 32'd1);
    check_val("bp_busy", 32'(busy), 32'd1);
    check_val("bp_we", 32'(buf_write_enable), 32'd0);
    check_val("bp_nobs", obs.size(), 32'd1);
    send(8'd17);
    cycle();
    check_val("bp_nobs2", obs.size(), 32'd2);
    if (obs.size() == 2) check_val("bp_grp2", 32'(obs[1]), 32'h1011);

    // Streaming one word per cycle.
    do_reset();
    buf_ready = 1'b1;
    for (int i = 16; i <= 25; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      cycle();
      check_val("st_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    cycle();
    cycle();
    check_val("st_gc", 32'(group_count), 32'd5);
    check_val("st_nobs", obs.size(), 32'd5);
    for (int i = 0; i < 5 && i < obs.size(); i++)
      check_val("st_grp", 32'(obs[i]), 32'({8'(16 + 2 * i), 8'(17 + 2 * i)}));

    // Flush after one word.
    do_reset();
    buf_ready = 1'b1;
    send(8'd40);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check_val("fl_din", 32'(buf_din), 32'h2800);
    cycle();
    cycle();
    check_val("fl_nobs", obs.size(), 32'd1);
    // Flush on an empty packer.
    obs.delete();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    cycle();
    check_val("fl_empty_nobs", obs.size(), 32'd0);
    check_val("fl_empty_gc", 32'(group_count), 32'd1);
    // Flush with a same-cycle word.
    flush = 1'b1; in_valid = 1'b1; in_data = 8'd41;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check_val("fl_word_din", 32'(buf_din), 32'h2900);
    cycle();
    cycle();
    check_val("fl_word_nobs", obs.size(), 32'd1);
    check_val("fl_word_gc", 32'(group_count), 32'd2);

    // Reset while a complete group is held.
    do_reset();
    buf_ready = 1'b1;
    send(8'd50);
    buf_ready = 1'b0;
    send(8'd51);
    cycle();
    check_val("mr_we_before", 32'(buf_write_enable), 32'd1);
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    check_val("mr_we", 32'(buf_write_enable), 32'd0);
    check_val("mr_gc", 32'(group_count), 32'd0);
    buf_ready = 1'b1;
    cycle();
    check_val("mr_nobs", obs.size(), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 99) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      flush     = ($urandom_range(0, 7) == 0);
      buf_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/row_packer.md
Name: row_packer

Overview:
- Upstream feeder of the circular buffer.
- Accepts a stream of single ROW_SIZE-bit words over a valid/ready handshake and packs PAR_WRITE consecutive words into one wide group.
- Offers each group to the circular buffer's write port, holding it until the buffer signals ready.
- A flush input zero-pads and pushes a partial group at the end of a stream.

Parameters:
- ROW_SIZE, 8, width of one input word in bits.
- PAR_WRITE, 2, words per packed group; equals the circular buffer's PAR_WRITE; legal range 1..16.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream word present.
- in_data  input  ROW_SIZE  upstream word.
- in_ready  output  1  packer accepts in_data this cycle.
- flush  input  1  single-cycle request to pad and push a partial group.
- buf_ready  input  1  circular buffer can take a group this cycle; wired to the buffer's ready.
- buf_write_enable  output  1  group valid on buf_din; wired to the buffer's write_enable.
- buf_din  output  ROW_SIZE*PAR_WRITE  packed group; wired to the buffer's din.
- busy  output  1  cnt != 0, i.e. a partial or complete group is held.
- group_count  output  16  number of groups transferred since reset; wraps at 2^16.

Behaviour:
- Word accept: occurs on an edge where in_valid && in_ready.
- Group transfer: occurs on an edge where buf_write_enable && buf_ready.
- Internal state: pack register of PAR_WRITE slots; fill counter cnt, 0..PAR_WRITE, width clog2(PAR_WRITE+1).
- Reset (rst==0 at an edge), taking priority over all other inputs:
  - cnt=0, pack register=0, group_count=0.
  - Outputs: buf_write_enable=0, in_ready=1 from the next cycle, busy=0, buf_din=0.
  - A held group is discarded, not pushed.
- Packing order:
  - The first accepted word of a group occupies the most-significant slice, buf_din[ROW_SIZE*PAR_WRITE-1 -: ROW_SIZE].
  - Later words fill successively lower slices; the last word occupies [ROW_SIZE-1:0].
- buf_write_enable = (cnt==PAR_WRITE), registered state only.
  - No combinational path from in_valid or flush to buf_write_enable.
  - buf_din is stable while buf_write_enable=1 and buf_ready=0.
- in_ready = (cnt<PAR_WRITE) || buf_ready.
  - The buf_ready term gives pass-through: when the held group transfers on the same edge as a word accept, the new word loads slot 0 and cnt becomes 1.
  - This sustains one word per cycle with buf_ready held high.
- Latency: the word completing a group is accepted at edge k; buf_write_enable=1 in the cycle after edge k; earliest transfer at edge k+1.
- cnt update per edge:
  - transfer only: 0.
  - accept only: cnt+1.
  - transfer and accept: 1.
  - neither: unchanged.
- Flush:
  - Sampled only when 1<=cnt<PAR_WRITE after accounting for a same-cycle accept.
  - Remaining lower slots are zero-filled and cnt becomes PAR_WRITE.
  - flush with in_valid && in_ready in the same cycle: the word is packed first, then padding applies.
  - Ignored when the resulting cnt is 0; a flush never pushes an empty group.
  - Ignored when the resulting cnt is already PAR_WRITE.
- PAR_WRITE=1: every accepted word is immediately a full group; flush has no effect.
- Backpressure: while buf_ready=0 and cnt==PAR_WRITE, in_ready=0 and in_data is not sampled; no word is lost or duplicated.
- group_count increments by 1 on each transfer.

Test Plan (ROW_SIZE=8, PAR_WRITE=2 unless stated):
- Reset: hold rst=0 for 2 cycles with in_valid=1 and flush=1 -> buf_write_enable=0, group_count=0, busy=0; in_ready=1 in the cycle after release.
- Basic pack: send 12 then 13 with buf_ready=1 -> one cycle later buf_write_enable=1 and buf_din=16'h0C0D; after the transfer edge group_count=1 and busy=0.
- Backpressure: buf_ready=0, send 14, 15, 16 -> buf_din=16'h0E0F is held stable and in_ready=0 with 16 pending. Raise buf_ready -> transfer occurs, 16 is accepted on the same edge, cnt=1, group_count increments once.
- Streaming: in_valid=1 for words 16..25 back-to-back with buf_ready=1 -> 5 groups {16,17}..{24,25} in order; in_ready never drops; group_count=5.
- Flush: send 40 then pulse flush -> buf_din=16'h2800. Flush with cnt=0 -> no push. flush plus in_valid with word 41 at cnt=0 -> buf_din=16'h2900.
- Mid-operation reset: accept 50, set buf_ready=0, complete a group with 51, assert rst=0 while buf_write_enable=1 -> buf_write_enable=0 next cycle; the group is never transferred; group_count=0.
